// File: rtl/pm_dm_memory.sv
// Program/data memory: single-port PM with read/write, DM with a post-reset
// clear sweep and an execute+1 write pipeline that forwards to same-cycle reads.
module pm_dm_memory #(
    parameter int PMA_SIZE = 16,
    parameter int PMD_SIZE = 32,
    parameter int DMA_SIZE = 16,
    parameter int DMD_SIZE = 16,
    parameter int DM_CLEAR = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ps_pm_cslt,
    input  logic                ps_pm_wrb,
    input  logic [PMA_SIZE-1:0] ps_pm_add,
    input  logic [PMD_SIZE-1:0] ps_pm_wdt,
    output logic [PMD_SIZE-1:0] pm_ps_op,
    input  logic                ps_dm_cslt,
    input  logic                ps_dm_wrb,
    input  logic [DMA_SIZE-1:0] dg_dm_add,
    input  logic [DMD_SIZE-1:0] bc_dt,
    output logic [DMD_SIZE-1:0] dm_bc_dt,
    output logic                mem_rdy,
    output logic                dbg_state
);

    localparam int PM_DEPTH = 1 << PMA_SIZE;
    localparam int DM_DEPTH = 1 << DMA_SIZE;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t state;

    logic [PMD_SIZE-1:0] pm [0:PM_DEPTH-1];
    logic [DMD_SIZE-1:0] dm [0:DM_DEPTH-1];

    logic [DMA_SIZE-1:0] clr_add;
    logic [DMA_SIZE-1:0] pend_add;
    logic                pend_v;

    logic pm_rd, pm_wr, dm_rd, dm_wr, fwd;

    // Request contract: a strobe (ps_*_cslt) is sampled on a rising edge and is
    // accepted only when mem_rdy was 1 before that edge; there is no backpressure
    // once mem_rdy is high, so every accepted request completes at fixed latency.
    assign pm_rd = mem_rdy && ps_pm_cslt && !ps_pm_wrb;
    assign pm_wr = mem_rdy && ps_pm_cslt &&  ps_pm_wrb;
    assign dm_rd = mem_rdy && ps_dm_cslt && !ps_dm_wrb;
    assign dm_wr = mem_rdy && ps_dm_cslt &&  ps_dm_wrb;
    assign fwd   = pend_v && (pend_add == dg_dm_add);

    assign dbg_state = (state == ST_RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= (DM_CLEAR != 0) ? ST_CLEAR : ST_RUN;
            clr_add  <= '0;
            pend_v   <= 1'b0;
            pend_add <= '0;
            mem_rdy  <= 1'b0;
            pm_ps_op <= '0;
            dm_bc_dt <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_add <= clr_add + 1'b1;
                    if (clr_add == '1) begin
                        state   <= ST_RUN;
                        mem_rdy <= 1'b1;
                    end
                end
                default: mem_rdy <= 1'b1;
            endcase

            // A write request arms the pipeline; its data arrives on bc_dt next cycle.
            pend_v <= dm_wr;
            if (dm_wr) begin
                pend_add <= dg_dm_add;
            end

            if (pm_rd) begin
                pm_ps_op <= pm[ps_pm_add];
            end
            if (dm_rd) begin
                dm_bc_dt <= fwd ? bc_dt : dm[dg_dm_add];
            end
        end
    end

    // Arrays carry no reset; the clear sweep is gated so a held reset writes nothing.
    always_ff @(posedge clk) begin
        if (reset && state == ST_CLEAR) begin
            dm[clr_add] <= '0;
        end else if (pend_v) begin
            dm[pend_add] <= bc_dt;
        end
        if (pm_wr) begin
            pm[ps_pm_add] <= ps_pm_wdt;
        end
    end

endmodule
